// File: rtl/subbytes_share_arbiter_pkg.sv
// Shared types for the SubBytes sharing arbiter: requester owner encoding,
// grant-priority states and the in-flight tag record.
package subbytes_share_arbiter_pkg;

  localparam logic OWNER_RND = 1'b0;
  localparam logic OWNER_KEY = 1'b1;

  typedef enum logic {
    PRI_KEY = 1'b0,
    PRI_RND = 1'b1
  } pri_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/subbytes_share_arbiter_sb_tag_pipe.sv
// LATENCY-deep shift register that follows each SubBytes operation so its
// result can be routed back to the requester that issued it.
module sb_tag_pipe
  import subbytes_share_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_end,
  output logic busy
);

  tag_t stages [LATENCY];

  // Flush only kills the valid bits; owners are don't-care once invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= '{valid: tag_in.valid && !flush, owner: tag_in.owner};
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= '{valid: stages[i-1].valid && !flush, owner: stages[i-1].owner};
      end
    end
  end

  assign tag_end = stages[LATENCY-1];

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | stages[i].valid;
    end
  end

endmodule

// File: rtl/subbytes_share_arbiter.sv
// Shares one SubBytes datapath between the round datapath and key expansion:
// key-priority grant with an anti-starvation limit, tagged return routing.
module subbytes_share_arbiter
  import subbytes_share_arbiter_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int WORD_W     = 32,
  parameter int LATENCY    = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              rnd_req_valid,
  output logic              rnd_req_ready,
  input  logic [DATA_W-1:0] rnd_req_data,
  output logic              rnd_rsp_valid,
  output logic [DATA_W-1:0] rnd_rsp_data,
  input  logic              key_req_valid,
  output logic              key_req_ready,
  input  logic [WORD_W-1:0] key_req_data,
  output logic              key_rsp_valid,
  output logic [WORD_W-1:0] key_rsp_data,
  output logic              sb_valid_in,
  output logic [DATA_W-1:0] sb_data_in,
  input  logic              sb_valid_out,
  input  logic [DATA_W-1:0] sb_data_out,
  output logic              busy,
  output logic              err_sync
);

  localparam int CNT_W = $clog2(MAX_CONSEC + 1);

  pri_state_t        state;
  logic [CNT_W-1:0]  consec_cnt;
  logic              grant_en;
  logic              key_grant;
  logic              rnd_grant;
  logic [DATA_W-1:0] issue_data;
  logic [DATA_W-1:0] last_data;
  logic              rsp_en;
  tag_t              tag_in;
  tag_t              tag_end;

  // No grant while held in reset or during a flush cycle.
  assign grant_en = reset && !flush;

  always_comb begin
    key_grant = 1'b0;
    rnd_grant = 1'b0;
    if (grant_en) begin
      if (state == PRI_KEY) begin
        key_grant = key_req_valid;
        rnd_grant = rnd_req_valid && !key_req_valid;
      end else begin
        rnd_grant = rnd_req_valid;
        key_grant = key_req_valid && !rnd_req_valid;
      end
    end
  end

  assign rnd_req_ready = rnd_grant;
  assign key_req_ready = key_grant;

  always_comb begin
    issue_data = last_data;
    if (rnd_grant) begin
      issue_data = rnd_req_data;
    end else if (key_grant) begin
      issue_data = DATA_W'(key_req_data);
    end
  end

  assign sb_valid_in = rnd_grant || key_grant;
  assign sb_data_in  = issue_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_data <= '0;
    end else if (sb_valid_in) begin
      last_data <= issue_data;
    end
  end

  // Key wins by default; after MAX_CONSEC key grants that made a round
  // request wait, the round request gets exactly one turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PRI_KEY;
      consec_cnt <= '0;
    end else if (flush) begin
      state      <= PRI_KEY;
      consec_cnt <= '0;
    end else begin
      case (state)
        PRI_KEY: begin
          if (key_grant && rnd_req_valid) begin
            consec_cnt <= consec_cnt + 1'b1;
            if (consec_cnt + 1'b1 == CNT_W'(MAX_CONSEC)) begin
              state <= PRI_RND;
            end
          end else if (rnd_grant || !rnd_req_valid) begin
            consec_cnt <= '0;
          end
        end
        PRI_RND: begin
          if (rnd_grant || !rnd_req_valid) begin
            state      <= PRI_KEY;
            consec_cnt <= '0;
          end
        end
        default: begin
          state      <= PRI_KEY;
          consec_cnt <= '0;
        end
      endcase
    end
  end

  assign tag_in = '{valid: sb_valid_in, owner: key_grant ? OWNER_KEY : OWNER_RND};

  sb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .tag_in  (tag_in),
    .tag_end (tag_end),
    .busy    (busy)
  );

  // A result leaving SubBytes in a flush cycle belongs to a dropped op.
  assign rsp_en        = tag_end.valid && !flush;
  assign rnd_rsp_valid = rsp_en && (tag_end.owner == OWNER_RND);
  assign key_rsp_valid = rsp_en && (tag_end.owner == OWNER_KEY);
  assign rnd_rsp_data  = rnd_rsp_valid ? sb_data_out : '0;
  assign key_rsp_data  = key_rsp_valid ? sb_data_out[WORD_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sync <= 1'b0;
    end else if (sb_valid_out != tag_end.valid) begin
      err_sync <= 1'b1;
    end
  end

endmodule
